call_latch: RTL and testbench
=============================

// Module: call_latch
// PURPOSE
//  Front end that sits directly upstream of the elevator controller's floorButton/internalButton inputs.
//  Takes raw, asynchronous push-button levels and synchronises and debounces them.
//  Converts each debounced press into a sticky request bit.
//  Merges those bits with the controller's serviced-request feedback (nextFloorButton/nextInternalButton)
//  to form the request vectors the controller consumes.
// PARAMETERS
//  DEBOUNCE_CLKS  1000000  clk cycles between debounce samples; min 1 (1 = sample every cycle)
//  CNT_W          20       prescaler width; must satisfy 2**CNT_W >= DEBOUNCE_CLKS
// PORTS
//  clk            in   1   system clock
//  reset          in   1   synchronous, active-high
//  raw_floor_btn  in   14  hall buttons, async; floor f: bit 2(f-1)+1 = UP, bit 2(f-1) = DOWN
//  raw_int_btn    in   9   [9:1] cab buttons, async; 1..7 = floor, 8 = door open, 9 = door close
//  elev_floor_btn in   14  controller nextFloorButton (serviced bits already cleared)
//  elev_int_btn   in   9   [9:1] controller nextInternalButton
//  floor_btn      out  14  registered hall requests -> controller floorButton
//  int_btn        out  9   [9:1] registered cab requests -> controller internalButton
//  press_any      out  1   registered 1-cycle pulse, any new debounced press this cycle
// BEHAVIOUR
//  Reset: floor_btn = 0, int_btn = 0, press_any = 0.
//   Synchroniser flops, sample windows, debounced levels and prescaler all cleared.
//  Sync: each raw bit passes through a 2-flop synchroniser before use.
//  Prescaler: cnt counts 0..DEBOUNCE_CLKS-1 and wraps to 0.
//   tick = (cnt == DEBOUNCE_CLKS-1).
//  Sample window: on each tick, the synced bit is shifted into a per-bit 2-deep history.
//   Debounced level deb goes to 1 when history == 2'b11 and the synced bit is 1.
//   deb goes to 0 when history == 2'b00 and the synced bit is 0; otherwise deb holds.
//   deb therefore needs 3 consecutive agreeing samples to change.
//  Press pulse: p = deb & ~deb_q, where deb_q is deb delayed one clk.
//   Exactly one pulse per debounced rising edge; holding a button never re-fires.
//  Request update, every clk:
//   floor_btn <= (elev_floor_btn | p_floor) & VALID_MASK
//   int_btn[7:1] <= elev_int_btn[7:1] | p_int[7:1]
//   int_btn[9:8] <= deb[9:8] (momentary level; not latched, feedback ignored)
//  VALID_MASK: bit 0 (floor-1 DOWN) and bit 13 (floor-7 UP) are forced to 0 at all times.
//  Latency: output bit is set on the 2nd clk edge after the tick that debounces the press.
//   Worst case from a stable raw level: 3*DEBOUNCE_CLKS + 4 clks.
//  Simultaneous press and service of the same bit: press wins, bit ends set.
//  Bounce: any pattern that does not give 3 agreeing samples leaves deb and outputs unchanged.
//  press_any <= |p (all 23 bits); 1-cycle pulse, one clk after p.
//  Reset mid-debounce: all in-flight state is discarded.
//   A button still held after reset must re-debounce (3 ticks) and then fires once.
// CONFIGURATION
//  CALL_CANCEL_EN defined:
//   A press pulse on cab bit k (1..7) whose elev_int_btn[k] is already 1 clears the bit instead:
//   int_btn[k] <= elev_int_btn[k] ^ p_int[k].
//   Hall bits and bits 9:8 are unaffected.
//  CALL_CANCEL_EN undefined: presses only set bits (OR rule above); a repeat press is a no-op.
// TESTING (DEBOUNCE_CLKS = 4 for all)
//  1. reset 3 clks, then raw_int_btn[5] = 1 held.
//     -> int_btn[5] = 1 within 16 clks; press_any pulses exactly once; holding 100 clks gives no further pulse.
//  2. raw_floor_btn[4] toggles every 3 clks for 60 clks.
//     -> floor_btn[4] stays 0, press_any never asserts.
//  3. raw_floor_btn[0] and [13] held 40 clks.
//     -> floor_btn[0] = floor_btn[13] = 0 throughout; press_any still pulses once.
//  4. int_btn[3] latched; set elev_int_btn[3] = 0 on the same clk the press pulse for bit 3 fires.
//     -> int_btn[3] = 1; one clk later with no press, int_btn[3] = 0.
//  5. raw_int_btn[8] held 40 clks, then released.
//     -> int_btn[8] follows debounced level high, then low after 3 low samples.
//  6. With CALL_CANCEL_EN: elev_int_btn[2] = 1, debounced press on bit 2.
//     -> int_btn[2] = 0. Without the macro -> int_btn[2] = 1.

Source files
------------

// File: rtl/call_latch.sv
// Call-button front end: synchronises and debounces the raw hall and cab buttons, then merges the presses with the controller's request feedback.
// Optional `CALL_CANCEL_EN: a press on a cab floor call that is already pending cancels that call.
module call_latch #(
  parameter int DEBOUNCE_CLKS = 1000000,
  parameter int CNT_W         = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] raw_floor_btn,
  input  logic [9:1]  raw_int_btn,
  input  logic [13:0] elev_floor_btn,
  input  logic [9:1]  elev_int_btn,
  output logic [13:0] floor_btn,
  output logic [9:1]  int_btn,
  output logic        press_any
);

  localparam int              NB         = 23;
  localparam logic [13:0]     VALID_MASK = 14'b01_1111_1111_1110;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CLKS - 1);

  // Bit layout of the combined vectors: [13:0] hall buttons, [22:14] cab buttons 1..9.
  logic [NB-1:0]    sync1_q, sync1_d;
  logic [NB-1:0]    sync2_q, sync2_d;
  logic [NB-1:0]    hist_new_q, hist_new_d;
  logic [NB-1:0]    hist_old_q, hist_old_d;
  logic [NB-1:0]    deb_q, deb_d;
  logic [NB-1:0]    deb_dly_q, deb_dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [13:0]      floor_q, floor_d;
  logic [9:1]       int_q, int_d;
  logic             press_any_q, press_any_d;
  logic             tick;
  logic [NB-1:0]    p;
  logic [NB-1:0]    deb_set;
  logic [NB-1:0]    deb_clr;

  // Next-state logic for the synchroniser, prescaler, debounce windows and request outputs.
  always_comb begin
    sync1_d     = {raw_int_btn, raw_floor_btn};
    sync2_d     = sync1_q;
    tick        = (cnt_q == CNT_LAST);
    hist_new_d  = hist_new_q;
    hist_old_d  = hist_old_q;
    deb_d       = deb_q;
    deb_set     = hist_old_q & hist_new_q & sync2_q;
    deb_clr     = ~hist_old_q & ~hist_new_q & ~sync2_q;
    deb_dly_d   = deb_q;
    p           = deb_q & ~deb_dly_q;
    floor_d     = (elev_floor_btn | p[13:0]) & VALID_MASK;
    int_d       = int_q;
    press_any_d = |p;

    if (tick) begin
      cnt_d      = '0;
      hist_old_d = hist_new_q;
      hist_new_d = sync2_q;
      // Level changes only after three consecutive agreeing samples.
      deb_d      = deb_set | (deb_q & ~deb_clr);
    end else begin
      cnt_d      = cnt_q + CNT_W'(1);
    end

`ifdef CALL_CANCEL_EN
    int_d[7:1] = elev_int_btn[7:1] ^ p[20:14];
`else
    int_d[7:1] = elev_int_btn[7:1] | p[20:14];
`endif
    // Door open/close are momentary: they track the debounced level, not the feedback.
    int_d[9:8] = deb_q[22:21];
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      hist_new_q  <= '0;
      hist_old_q  <= '0;
      deb_q       <= '0;
      deb_dly_q   <= '0;
      cnt_q       <= '0;
      floor_q     <= '0;
      int_q       <= '0;
      press_any_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      hist_new_q  <= hist_new_d;
      hist_old_q  <= hist_old_d;
      deb_q       <= deb_d;
      deb_dly_q   <= deb_dly_d;
      cnt_q       <= cnt_d;
      floor_q     <= floor_d;
      int_q       <= int_d;
      press_any_q <= press_any_d;
    end
  end

  assign floor_btn = floor_q;
  assign int_btn   = int_q;
  assign press_any = press_any_q;

endmodule

// File: tb/tb_call_latch.sv
// Directed bench for call_latch with DEBOUNCE_CLKS = 4; a simple controller model
// can loop the registered requests back as the serviced-request feedback.
module tb_call_latch;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] raw_floor;
  logic [9:1]  raw_int;
  logic [13:0] elev_floor, elev_floor_drv;
  logic [9:1]  elev_int, elev_int_drv;
  logic [13:0] floor_o;
  logic [9:1]  int_o;
  logic        press_any;
  logic        loop_en;

  int n_cmp = 0;
  int n_err = 0;
  int pa_cnt = 0;

  always #5 clk = ~clk;

  assign elev_floor = loop_en ? floor_o : elev_floor_drv;
  assign elev_int   = loop_en ? int_o   : elev_int_drv;

  call_latch #(.DEBOUNCE_CLKS(4), .CNT_W(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .raw_floor_btn (raw_floor),
    .raw_int_btn   (raw_int),
    .elev_floor_btn(elev_floor),
    .elev_int_btn  (elev_int),
    .floor_btn     (floor_o),
    .int_btn       (int_o),
    .press_any     (press_any)
  );

  // Counts clocks with press_any high, sampled just after each active edge.
  always @(posedge clk) begin
    #1;
    if (press_any === 1'b1) pa_cnt <= pa_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits (bounded) for cab bit b to read 1; n = clock edges elapsed, or budget on timeout.
  task automatic wait_int(input int b, input int budget, output int n);
    n = 0;
    while (n < budget && int_o[b] !== 1'b1) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    int base;
    int zeros;
    logic seen;

    reset          = 1'b1;
    raw_floor      = 14'd0;
    raw_int        = 9'd0;
    elev_floor_drv = 14'd0;
    elev_int_drv   = 9'd0;
    loop_en        = 1'b1;
    clks(3);
    check("rst_floor", 32'(floor_o), 32'd0);
    check("rst_int", 32'(int_o), 32'd0);
    check("rst_press_any", 32'(press_any), 32'd0);

    // 1: cab 5 held from reset release; deterministic prescaler phase gives 13 clks.
    base       = pa_cnt;
    reset      = 1'b0;
    raw_int[5] = 1'b1;
    wait_int(5, 40, n);
    check("t1_latency", 32'(n), 32'd13);
    check("t1_press_any_now", 32'(press_any), 32'd1);
    clks(100);
    check("t1_latched", 32'(int_o[5]), 32'd1);
    check("t1_one_pulse", 32'(pa_cnt - base), 32'd1);
    raw_int[5] = 1'b0;
    clks(20);

    // 2: hall bit 4 bouncing every 3 clks never debounces.
    base = pa_cnt;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      raw_floor[4] = ~raw_floor[4];
      for (int j = 0; j < 3; j++) begin
        clks(1);
        seen = seen | floor_o[4];
      end
    end
    raw_floor[4] = 1'b0;
    clks(20);
    check("t2_bounce_floor4", 32'(seen), 32'd0);
    check("t2_bounce_no_pulse", 32'(pa_cnt - base), 32'd0);

    // 3: nonexistent directions (floor-1 DOWN, floor-7 UP) never latch but still pulse.
    base          = pa_cnt;
    seen          = 1'b0;
    raw_floor[0]  = 1'b1;
    raw_floor[13] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      clks(1);
      seen = seen | floor_o[0] | floor_o[13];
    end
    check("t3_masked_bits", 32'(seen), 32'd0);
    check("t3_one_pulse", 32'(pa_cnt - base), 32'd1);
    raw_floor[0]  = 1'b0;
    raw_floor[13] = 1'b0;
    clks(20);

    // 4: press coincides with service (feedback 0): press wins for one clock.
    loop_en      = 1'b0;
    elev_int_drv = 9'd0;
    clks(2);
    raw_int[3] = 1'b1;
    wait_int(3, 40, n);
    check("t4_latency_window", 32'(n >= 12 && n <= 16), 32'd1);
    clks(1);
    check("t4_serviced_clears", 32'(int_o[3]), 32'd0);
    raw_int[3] = 1'b0;
    clks(20);

    // 5: door-open follows the debounced level and ignores feedback.
    base       = pa_cnt;
    raw_int[8] = 1'b1;
    wait_int(8, 40, n);
    check("t5_rise_window", 32'(n >= 12 && n <= 16), 32'd1);
    clks(25);
    check("t5_held_high", 32'(int_o[8]), 32'd1);
    elev_int_drv[9:8] = 2'b11;
    raw_int[8]        = 1'b0;
    clks(10);
    check("t5_still_high", 32'(int_o[8]), 32'd1);
    clks(6);
    check("t5_fell", 32'(int_o[8]), 32'd0);
    check("t5_door_close_idle", 32'(int_o[9]), 32'd0);
    check("t5_one_pulse", 32'(pa_cnt - base), 32'd1);
    elev_int_drv = 9'd0;
    clks(5);

    // 6: repeat press on a pending cab call.
    base            = pa_cnt;
    elev_int_drv[2] = 1'b1;
    clks(2);
    check("t6_pending", 32'(int_o[2]), 32'd1);
    zeros      = 0;
    raw_int[2] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      clks(1);
      if (int_o[2] === 1'b0) zeros++;
    end
`ifdef CALL_CANCEL_EN
    check("t6_cancel_clocks", 32'(zeros), 32'd1);
`else
    check("t6_cancel_clocks", 32'(zeros), 32'd0);
`endif
    check("t6_one_pulse", 32'(pa_cnt - base), 32'd1);
    raw_int[2]   = 1'b0;
    elev_int_drv = 9'd0;
    clks(20);

    // 7: reset mid-debounce discards progress; held button re-debounces and fires once.
    loop_en    = 1'b1;
    raw_int[6] = 1'b1;
    clks(6);
    reset = 1'b1;
    clks(2);
    check("t7_reset_int", 32'(int_o), 32'd0);
    base  = pa_cnt;
    reset = 1'b0;
    wait_int(6, 40, n);
    check("t7_latency", 32'(n), 32'd13);
    clks(20);
    check("t7_one_pulse", 32'(pa_cnt - base), 32'd1);
    check("t7_latched", 32'(int_o[6]), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
